// File: rtl/procb_state_store_pkg.sv
// Shared widths and index helpers for the procb saved-state store.
package procb_state_store_pkg;

  localparam int PROCB_SAVE_MSB = 127;

  // Index of the most significant set bit; 0 for inputs of 0 or 1.
  function automatic int msb(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((x >> i) > 1) r = i + 1;
    end
    return r;
  endfunction

  function automatic int entry_addr(input int core, input int thread, input int n_threads);
    return core * n_threads + thread;
  endfunction

  function automatic logic in_range(input int core, input int thread,
                                    input int n_cores, input int n_threads);
    return (core < n_cores) && (thread < n_threads);
  endfunction

endpackage

// File: rtl/procb_state_ram.sv
// Distributed RAM holding the saved SHA512 state words; synchronous write, asynchronous read.
module procb_state_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are deliberately not reset; the valid flags in the parent gate their use.
  (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/procb_state_store.sv
// Per-thread saved-state store: data RAM plus valid flags, occupancy count and bypassed read port.
module procb_state_store
  import procb_state_store_pkg::*;
#(
  parameter int N_CORES       = 4,
  parameter int N_CORES_MSB   = msb(N_CORES - 1),
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = msb(N_THREADS - 1),
  parameter int DATA_WIDTH    = PROCB_SAVE_MSB + 1,
  localparam int N_ENTRIES    = N_CORES * N_THREADS,
  localparam int CNT_MSB      = msb(N_ENTRIES)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   wr_en,
  input  logic [N_CORES_MSB:0]   wr_core_num,
  input  logic [N_THREADS_MSB:0] wr_thread_num,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   inv_en,
  input  logic [N_CORES_MSB:0]   inv_core_num,
  input  logic [N_THREADS_MSB:0] inv_thread_num,
  input  logic                   clear_all,
  input  logic                   rd_en,
  input  logic [N_CORES_MSB:0]   rd_core_num,
  input  logic [N_THREADS_MSB:0] rd_thread_num,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic [CNT_MSB:0]       n_valid,
  output logic                   full,
  output logic                   empty
);

  localparam int ADDR_W = msb(N_ENTRIES - 1) + 1;
  localparam int CNT_W  = CNT_MSB + 1;

  logic [ADDR_W-1:0]     wr_addr, inv_addr, rd_addr;
  logic                  wr_ok, inv_ok, rd_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [N_ENTRIES-1:0]  valid_reg, valid_next;
  logic [CNT_W-1:0]      n_valid_reg, n_valid_next;
  logic                  wr_sets, inv_clears;
  logic [DATA_WIDTH-1:0] dout_reg;
  logic                  dout_valid_reg, full_reg, empty_reg;

  assign wr_addr  = ADDR_W'(entry_addr(int'(wr_core_num), int'(wr_thread_num), N_THREADS));
  assign inv_addr = ADDR_W'(entry_addr(int'(inv_core_num), int'(inv_thread_num), N_THREADS));
  assign rd_addr  = ADDR_W'(entry_addr(int'(rd_core_num), int'(rd_thread_num), N_THREADS));
  assign wr_ok    = wr_en  && in_range(int'(wr_core_num), int'(wr_thread_num), N_CORES, N_THREADS);
  assign inv_ok   = inv_en && in_range(int'(inv_core_num), int'(inv_thread_num), N_CORES, N_THREADS);
  assign rd_ok    = in_range(int'(rd_core_num), int'(rd_thread_num), N_CORES, N_THREADS);

  procb_state_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (N_ENTRIES),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .CLK   (CLK),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (din),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // Per-entry priority: write hit sets, then clear_all / invalidate hit clear, else hold.
  for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_flag
    assign valid_next[gi] = (wr_ok && wr_addr == ADDR_W'(gi)) ? 1'b1 :
                            (clear_all || (inv_ok && inv_addr == ADDR_W'(gi))) ? 1'b0 :
                            valid_reg[gi];
  end

  // Incremental popcount; a same-address invalidate is overridden by the write.
  always_comb begin
    wr_sets    = wr_ok && !valid_reg[wr_addr];
    inv_clears = inv_ok && valid_reg[inv_addr] && !(wr_ok && wr_addr == inv_addr);
    if (clear_all)
      n_valid_next = wr_ok ? CNT_W'(1) : '0;
    else
      n_valid_next = n_valid_reg + CNT_W'(wr_sets) - CNT_W'(inv_clears);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_reg      <= '0;
      n_valid_reg    <= '0;
      full_reg       <= 1'b0;
      empty_reg      <= 1'b1;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      valid_reg   <= valid_next;
      n_valid_reg <= n_valid_next;
      full_reg    <= (n_valid_next == CNT_W'(N_ENTRIES));
      empty_reg   <= (n_valid_next == '0);
      if (rd_en) begin
        if (!rd_ok) begin
          dout_reg       <= '0;
          dout_valid_reg <= 1'b0;
        end else if (wr_ok && wr_addr == rd_addr) begin
          dout_reg       <= din;
          dout_valid_reg <= 1'b1;
        end else begin
          // valid_next already folds in same-cycle invalidate and clear_all.
          dout_reg       <= ram_rdata;
          dout_valid_reg <= valid_next[rd_addr];
        end
      end
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign n_valid    = n_valid_reg;
  assign full       = full_reg;
  assign empty      = empty_reg;

endmodule
